// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg: shared state encoding and BCD constants for the serial BCD adder.
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int         NIB     = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_nibble_adder_4b.sv
// ============================================================================
// nibble_adder_4b: combinational 4-bit ripple-carry adder shared by all digits.
// Rev 1.0
// ============================================================================
`default_nettype none

module nibble_adder_4b
  import bcd_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  logic [NIB:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIB; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIB];
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// bcd_serial_add_ctrl: digit-serial BCD adder, one digit per clock, LSD first.
// Optional BCD_SUB_EN adds ten's-complement subtraction (sub/borrow). Rev 1.0
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int DW   = NIB * NDIG
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
`ifdef BCD_SUB_EN
  input  logic          sub,
  output logic          borrow,
`endif
  input  logic [DW-1:0] a_bcd,
  input  logic [DW-1:0] b_bcd,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum_bcd,
  output logic          cout,
  output logic          err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          c_q, c_d;
`ifdef BCD_SUB_EN
  logic          sub_q, sub_d;
  logic          borrow_q, borrow_d;
`endif

  logic [NIB-1:0] a_dig, b_dig, nib_sum, digit;
  logic           nib_co, c_next, bad_digit;
  logic [NIB:0]   s5;

  assign a_dig = a_q[NIB-1:0];
`ifdef BCD_SUB_EN
  assign b_dig = sub_q ? (BCD_MAX - b_q[NIB-1:0]) : b_q[NIB-1:0];
`else
  assign b_dig = b_q[NIB-1:0];
`endif

  nibble_adder_4b u_nib_add (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (c_q),
    .sum  (nib_sum),
    .cout (nib_co)
  );

  // Decimal correction: any 5-bit sum above 9 wraps by +6 and carries.
  assign s5     = {nib_co, nib_sum};
  assign c_next = (s5 > {1'b0, BCD_MAX});
  assign digit  = c_next ? (nib_sum + BCD_ADJ) : nib_sum;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if ((a_q[NIB*i +: NIB] > BCD_MAX) || (b_q[NIB*i +: NIB] > BCD_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
`ifdef BCD_SUB_EN
    sub_d    = sub_q;
    borrow_d = borrow_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
          a_d     = a_bcd;
          b_d     = b_bcd;
          sum_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
`ifdef BCD_SUB_EN
          sub_d   = sub;
          c_d     = sub;
`else
          c_d     = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        err_d   = bad_digit;
        idx_d   = '0;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        sum_d = {digit, sum_q[DW-1:NIB]};
        a_d   = a_q >> NIB;
        b_d   = b_q >> NIB;
        c_d   = c_next;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NDIG - 1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = c_next;
`ifdef BCD_SUB_EN
          borrow_d = ~c_next;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q    <= 1'b0;
      borrow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
`ifdef BCD_SUB_EN
      sub_q    <= sub_d;
      borrow_q <= borrow_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_bcd = sum_q;
  assign cout    = cout_q;
  assign err     = err_q;
`ifdef BCD_SUB_EN
  assign borrow  = borrow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// tb_bcd_serial_add_ctrl: vector table, corner sequences and randomized ops
// against a decimal-arithmetic reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

  localparam int NDIG = 4;
  localparam int DW   = 4 * NDIG;
  localparam int POW  = 10 ** NDIG;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic          sub    = 1'b0;
  logic [DW-1:0] a_bcd  = '0;
  logic [DW-1:0] b_bcd  = '0;
  logic [DW-1:0] sum_bcd;
  logic          busy, done, cout, err, borrow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start),
`ifdef BCD_SUB_EN
    .sub      (sub),
    .borrow   (borrow),
`endif
    .a_bcd    (a_bcd),
    .b_bcd    (b_bcd),
    .busy     (busy),
    .done     (done),
    .sum_bcd  (sum_bcd),
    .cout     (cout),
    .err      (err)
  );
`ifndef BCD_SUB_EN
  assign borrow = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sum;
    logic          cout;
    logic          err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [DW-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [DW-1:0] int2bcd(input int v);
    logic [DW-1:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Starts one operation in the next cycle and returns at the done pulse.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                        output logic [DW-1:0] rs, output logic rc, output logic re,
                        output logic rb, output int lat, output int nbusy);
    @(negedge clk);
    a_bcd = a; b_bcd = b; sub = s; start = 1'b1;
    lat = 0; nbusy = 0; rs = '0; rc = 1'b0; re = 1'b0; rb = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a_bcd = DW'($urandom);
    b_bcd = DW'($urandom);
    for (int k = 1; k <= 20; k++) begin
      if (done) begin
        lat = k; rs = sum_bcd; rc = cout; re = err; rb = borrow;
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  logic [DW-1:0] rs, exp_sum;
  logic          rc, re, rb, exp_c;
  int            lat, nbusy, ndone, ia, ib, tot;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0458, 16'h0567, 16'h1025, 1'b0, 1'b0};
    vecs[3] = '{16'h00A3, 16'h0001, 16'h0104, 1'b0, 1'b1};
    vecs[4] = '{16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum",  {48'd0, sum_bcd}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_err",  {63'd0, err}, 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, rs, rc, re, rb, lat, nbusy);
      chk($sformatf("vec%0d_lat", i),  64'(lat), 64'd6);
      chk($sformatf("vec%0d_busy", i), 64'(nbusy), 64'd5);
      chk($sformatf("vec%0d_sum", i),  {48'd0, rs}, {48'd0, vecs[i].sum});
      chk($sformatf("vec%0d_cout", i), {63'd0, rc}, {63'd0, vecs[i].cout});
      chk($sformatf("vec%0d_err", i),  {63'd0, re}, {63'd0, vecs[i].err});
    end

    // Start held during busy and operands changed after capture.
    @(negedge clk);
    a_bcd = 16'h00A3; b_bcd = 16'h0001; sub = 1'b0; start = 1'b1;
    ndone = 0; lat = 0; rs = '0; re = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = (k >= 2 && k <= 4);
      if (k == 2) begin a_bcd = 16'h1111; b_bcd = 16'h2222; end
      if (done) begin ndone++; rs = sum_bcd; re = err; lat = k; end
    end
    start = 1'b0;
    chk("ign_ndone", 64'(ndone), 64'd1);
    chk("ign_lat",   64'(lat), 64'd6);
    chk("ign_sum",   {48'd0, rs}, 64'h0104);
    chk("ign_err",   {63'd0, re}, 64'd1);

    // Reset while digit 2 is being added.
    @(negedge clk);
    a_bcd = 16'h1234; b_bcd = 16'h4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_sum",  {48'd0, sum_bcd}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    resetn = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_nodone", 64'(ndone), 64'd0);
    run_op(16'h0458, 16'h0567, 1'b0, rs, rc, re, rb, lat, nbusy);
    chk("postrst_lat", 64'(lat), 64'd6);
    chk("postrst_sum", {48'd0, rs}, 64'h1025);

`ifdef BCD_SUB_EN
    run_op(16'h0100, 16'h0001, 1'b1, rs, rc, re, rb, lat, nbusy);
    chk("sub0_sum",    {48'd0, rs}, 64'h0099);
    chk("sub0_borrow", {63'd0, rb}, 64'd0);
    run_op(16'h0001, 16'h0002, 1'b1, rs, rc, re, rb, lat, nbusy);
    chk("sub1_sum",    {48'd0, rs}, 64'h9999);
    chk("sub1_borrow", {63'd0, rb}, 64'd1);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [DW-1:0] ra, rbb;
      logic          rsub;
      for (int i = 0; i < NDIG; i++) begin
        ra[4*i +: 4]  = 4'($urandom_range(9));
        rbb[4*i +: 4] = 4'($urandom_range(9));
      end
`ifdef BCD_SUB_EN
      rsub = 1'($urandom_range(1));
`else
      rsub = 1'b0;
`endif
      ia = bcd2int(ra);
      ib = bcd2int(rbb);
      tot = rsub ? (ia + (POW - 1 - ib) + 1) : (ia + ib);
      exp_sum = int2bcd(tot % POW);
      exp_c   = (tot >= POW);
      run_op(ra, rbb, rsub, rs, rc, re, rb, lat, nbusy);
      chk($sformatf("rnd%0d_lat", n),  64'(lat), 64'd6);
      chk($sformatf("rnd%0d_sum", n),  {48'd0, rs}, {48'd0, exp_sum});
      chk($sformatf("rnd%0d_cout", n), {63'd0, rc}, {63'd0, exp_c});
      chk($sformatf("rnd%0d_err", n),  {63'd0, re}, 64'd0);
`ifdef BCD_SUB_EN
      chk($sformatf("rnd%0d_borrow", n), {63'd0, rb}, {63'd0, ~exp_c});
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
- Sequencer that shares one 4-bit ripple nibble adder across NDIG BCD digits of two multi-digit operands, least-significant digit first, one digit per clock.
- Applies decimal correction (+6 on binary sum >9 or nibble carry) and chains the decimal carry between digits.
- Sits between the slide-switch/operand capture logic and the 7-segment digit decoders. Uses a start/busy/done handshake.

Parameters:
- NDIG, 4, number of BCD digits per operand (2..8).
- DW, 4*NDIG, derived operand width in bits. Not overridable.

Ports:
- CLOCK_50  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  request pulse; accepted only in IDLE.
- a_bcd  input  DW  operand A, packed BCD, digit 0 in bits [3:0].
- b_bcd  input  DW  operand B, packed BCD.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when sum_bcd/cout/err are valid.
- sum_bcd  output  DW  packed BCD result; held until the next accepted start.
- cout  output  1  decimal carry out of the top digit.
- err  output  1  at least one input digit was >9 (sticky per operation).

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; busy=0, done=0, sum_bcd=0, cout=0, err=0; digit index=0; operand registers cleared. Reset wins over every other event, including mid-ADD. A partial result is discarded.
- States: IDLE -> LOAD -> ADD -> DONE -> IDLE.
- IDLE: start=1 moves to LOAD. In the same edge, a_bcd and b_bcd are captured into shift registers, sum_bcd and err are cleared, and the carry register is set to 0.
- LOAD: busy=1. Scans the captured operands for digits >9 and sets err accordingly. Moves to ADD with index=0.
- ADD: one digit per cycle.
  - s5 = a_dig + b_dig + c. This is the 5-bit nibble adder result.
  - If s5 > 9: digit = (s5 + 6)[3:0] and c_next = 1. Otherwise digit = s5[3:0] and c_next = 0.
  - The digit is shifted into sum_bcd from the top; operand registers shift right by 4.
  - The index increments. After the index reaches NDIG-1, the state moves to DONE.
- DONE: cout = final c, done=1 for exactly one cycle, busy=0 in this cycle. Returns to IDLE.
- Latency: start edge to done pulse is NDIG+2 cycles (6 for NDIG=4). Back-to-back operations: start may be reasserted in the first IDLE cycle after DONE.
- start while not IDLE: ignored. No queueing. Operand inputs may change freely after capture.
- Invalid digits: the arithmetic still follows the rule above (result undefined as BCD); err=1 is reported with done.
- Wrap-around: all-9s + 1 gives sum=0, cout=1.

Optional Feature:
- Macro: BCD_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured with the operands at start.
  - If sub=1, each B digit is replaced by its nines complement (9-b) before adding, and the initial carry is 1.
  - The result is A-B in ten's complement. Port borrow (output, 1 bit) = ~cout, valid with done and reset to 0.
  - err also flags B digits >9 before complementing.
- When undefined: no sub/borrow ports; add-only.

Decomposition:
- Shared package bcd_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_ADD=2'd2, ST_DONE=2'd3.
  - BCD_MAX=4'd9, BCD_ADJ=4'd6.
  - nibble width constant NIB=4.
- One sub-module: nibble_adder_4b. It is a purely combinational 4-bit ripple-carry adder with a, b, cin in and sum[3:0], cout out, instantiated once.
- FSM, digit counter, shift registers and decimal correction stay in the top block.

Test Plan:
- Reset then start with A=0x1234, B=0x4321 -> done at cycle 6 after start; sum=0x5555, cout=0, err=0; busy high cycles 1..5.
- A=0x9999, B=0x0001 -> sum=0x0000, cout=1 (carry ripples through all digits).
- A=0x0458, B=0x0567 -> sum=0x1025, cout=0 (correction on digits 0, 1, 2).
- A=0x00A3, B=0x0001 -> err=1 with done; start pulses during busy are ignored (single done, result unchanged).
- resetn=0 during ADD digit 2 -> next cycle: busy=0, sum=0, no done. A new start then completes normally.
- (BCD_SUB_EN) A=0x0100, B=0x0001, sub=1 -> sum=0x0099, borrow=0. A=0x0001, B=0x0002 -> sum=0x9999, borrow=1.
